chip8_sprite_engine: RTL and testbench

// Parametrised sprite blitter for the CHIP-8 core; it offloads the DXYN draw loop from the CPU FSM.
// On start it fetches N sprite rows from main memory and XORs each row into a row-wide framebuffer (read-modify-write).
// It reports pixel collision for VF and supports SCHIP 16x16 sprites, plus a wrap or clip edge mode per draw.
// It sits between the CPU, the memory arbiter and the framebuffer RAM.

---
 rtl/chip8_sprite_engine_if.sv | 44 ++++
 rtl/chip8_sprite_engine.sv | 177 +++++++++++++++++
 tb/tb_chip8_sprite_engine.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_sprite_engine_if.sv
// chip8_sprite_engine_if
//   Bundles the sprite engine's CPU handshake, memory read port and
//   framebuffer row port.
//   slave  : engine side (takes draw requests, drives memory/fb strobes)
//   master : surrounding system side (CPU, memory arbiter, framebuffer RAM)
//   CPU    : start, x, y, n, base_addr, wide, clip_mode -> busy, done, collision
//   Memory : mem_read, mem_addr -> mem_data (MEM_LAT cycles later)
//   FB     : fb_rd, fb_row -> fb_rdata (next cycle); fb_we, fb_wdata
interface chip8_sprite_engine_if #(
    parameter int DISP_W = 64,
    parameter int DISP_H = 32,
    parameter int ADDR_W = 12
);
    localparam int ROW_W = $clog2(DISP_H);

    logic              start;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [3:0]        n;
    logic [ADDR_W-1:0] base_addr;
    logic              wide;
    logic              clip_mode;
    logic              busy;
    logic              done;
    logic              collision;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              fb_rd;
    logic [ROW_W-1:0]  fb_row;
    logic [DISP_W-1:0] fb_rdata;
    logic              fb_we;
    logic [DISP_W-1:0] fb_wdata;

    modport slave (
        input  start, x, y, n, base_addr, wide, clip_mode, mem_data, fb_rdata,
        output busy, done, collision, mem_read, mem_addr, fb_rd, fb_row, fb_we, fb_wdata
    );

    modport master (
        output start, x, y, n, base_addr, wide, clip_mode, mem_data, fb_rdata,
        input  busy, done, collision, mem_read, mem_addr, fb_rd, fb_row, fb_we, fb_wdata
    );
endinterface

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine
//   DXYN sprite blitter. Fetches sprite rows from memory and XORs each into
//   a row-wide framebuffer (read-modify-write), accumulating collision.
//   Supports 8-px rows (n!=0) and SCHIP 16x16 sprites (n==0, wide=1), with
//   per-draw wrap or clip at the display edges.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : chip8_sprite_engine_if.slave (handshake, memory, framebuffer)
module chip8_sprite_engine #(
    parameter int DISP_W  = 64,
    parameter int DISP_H  = 32,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 2,
    parameter int WIDE_EN = 1
) (
    input logic clk,
    input logic reset,
    chip8_sprite_engine_if.slave bus
);
    localparam int CW = $clog2(DISP_W);
    localparam int RW = $clog2(DISP_H);
    localparam int LW = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MWAIT, S_FBRD, S_FBWAIT, S_WRITE, S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     x0;
    logic [RW-1:0]     y0;
    logic [3:0]        n_q;
    logic [ADDR_W-1:0] base_q;
    logic              wide_q;
    logic              clip_q;
    logic [4:0]        row;
    logic              half;
    logic [LW-1:0]     wcnt;
    logic [7:0]        byte_hi;
    logic [7:0]        byte_lo;

    logic [4:0]        next_r;
    logic [4:0]        rows_total;
    logic [RW+5:0]     next_y_full;
    logic              skip_next;
    logic [RW-1:0]     cur_y;
    logic [ADDR_W-1:0] next_addr;
    logic              wide_go;
    logic [15:0]       sprite;
    logic [CW:0]       col;
    logic [DISP_W-1:0] mask;

    assign wide_go     = (WIDE_EN != 0) && bus.wide && (bus.n == 4'd0);
    assign next_r      = row + 5'd1;
    assign rows_total  = wide_q ? 5'd16 : {1'b0, n_q};
    assign next_y_full = (RW+6)'(y0) + (RW+6)'(next_r);
    assign skip_next   = clip_q && (next_y_full >= (RW+6)'(DISP_H));
    // Truncation to RW bits is the wrap (DISP_H is a power of two).
    assign cur_y       = y0 + RW'(row);
    assign next_addr   = wide_q ? base_q + ADDR_W'({next_r, 1'b0})
                                : base_q + ADDR_W'(next_r);

    // Sprite pixel k lands at column x0+k; col[CW] flags the right-edge
    // overflow, the low CW bits are the wrapped column. Column c lives in
    // bit DISP_W-1-c, i.e. the bitwise inverse of the column index.
    always_comb begin
        mask   = '0;
        col    = '0;
        sprite = {byte_hi, byte_lo};
        for (int unsigned k = 0; k < 16; k++) begin
            col = {1'b0, x0} + (CW+1)'(k);
            if (sprite[4'(15 - k)] && !(clip_q && col[CW]))
                mask[~col[CW-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            x0            <= '0;
            y0            <= '0;
            n_q           <= '0;
            base_q        <= '0;
            wide_q        <= 1'b0;
            clip_q        <= 1'b0;
            row           <= '0;
            half          <= 1'b0;
            wcnt          <= '0;
            byte_hi       <= '0;
            byte_lo       <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.collision <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.fb_rd     <= 1'b0;
            bus.fb_row    <= '0;
            bus.fb_we     <= 1'b0;
            bus.fb_wdata  <= '0;
        end else begin
            bus.mem_read <= 1'b0;
            bus.fb_rd    <= 1'b0;
            bus.fb_we    <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x0            <= CW'(bus.x);
                        y0            <= RW'(bus.y);
                        n_q           <= bus.n;
                        base_q        <= bus.base_addr;
                        wide_q        <= wide_go;
                        clip_q        <= bus.clip_mode;
                        row           <= '0;
                        half          <= 1'b0;
                        byte_lo       <= '0;
                        bus.collision <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.n != 4'd0 || wide_go) begin
                            state        <= S_FETCH;
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= bus.base_addr;
                        end else begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_MWAIT;
                    wcnt  <= '0;
                end
                S_MWAIT: begin
                    if (wcnt == LW'(MEM_LAT - 1)) begin
                        if (wide_q && !half) begin
                            byte_hi      <= bus.mem_data;
                            half         <= 1'b1;
                            state        <= S_FETCH;
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                        end else begin
                            if (wide_q) byte_lo <= bus.mem_data;
                            else        byte_hi <= bus.mem_data;
                            state      <= S_FBRD;
                            bus.fb_rd  <= 1'b1;
                            bus.fb_row <= cur_y;
                        end
                    end else begin
                        wcnt <= wcnt + LW'(1);
                    end
                end
                S_FBRD: state <= S_FBWAIT;
                S_FBWAIT: begin
                    state         <= S_WRITE;
                    bus.fb_we     <= 1'b1;
                    bus.fb_wdata  <= bus.fb_rdata ^ mask;
                    bus.collision <= bus.collision | (|(bus.fb_rdata & mask));
                end
                S_WRITE: begin
                    half <= 1'b0;
                    row  <= next_r;
                    if (next_r == rows_total || skip_next) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= S_FETCH;
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= next_addr;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_sprite_engine.sv
module tb_chip8_sprite_engine;
    localparam int DISP_W  = 64;
    localparam int DISP_H  = 32;
    localparam int ADDR_W  = 12;
    localparam int MEM_LAT = 2;
    localparam int WIDE_EN = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    chip8_sprite_engine_if #(.DISP_W(DISP_W), .DISP_H(DISP_H), .ADDR_W(ADDR_W)) bus ();

    chip8_sprite_engine #(
        .DISP_W(DISP_W), .DISP_H(DISP_H), .ADDR_W(ADDR_W),
        .MEM_LAT(MEM_LAT), .WIDE_EN(WIDE_EN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory: data valid exactly MEM_LAT cycles after mem_read
    logic [7:0]        mem [4096];
    logic [ADDR_W-1:0] rd_pipe [MEM_LAT];
    logic              rd_vld  [MEM_LAT];
    always @(posedge clk) begin
        rd_vld[0]  <= bus.mem_read;
        rd_pipe[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign bus.mem_data = rd_vld[MEM_LAT-1] ? mem[rd_pipe[MEM_LAT-1]] : 8'hA5;

    // ---------------- framebuffer RAM: read data valid the cycle after fb_rd
    logic [DISP_W-1:0] fb_mem [DISP_H];
    logic [DISP_W-1:0] fb_rdata_q;
    logic              fb_clear = 1'b0;
    always @(posedge clk) begin
        if (fb_clear) begin
            for (int i = 0; i < DISP_H; i++) fb_mem[i] <= '0;
        end else if (bus.fb_we) begin
            fb_mem[bus.fb_row] <= bus.fb_wdata;
        end
        fb_rdata_q <= bus.fb_rd ? fb_mem[bus.fb_row] : {(DISP_W/4){4'h9}};
    end
    assign bus.fb_rdata = fb_rdata_q;

    // ---------------- behavioural model state
    logic [DISP_W-1:0] model_fb [DISP_H];
    logic [ADDR_W-1:0] exp_rd_q [$];
    int                exp_row_q [$];
    logic [DISP_W-1:0] exp_wd_q [$];
    bit                exp_coll;
    bit                held_coll;
    int                exp_lat;
    int                start_cyc;
    int                last_lat;
    int                n_reads;
    int                n_writes;
    bit                active = 1'b0;
    bit                aborting = 1'b0;
    int                cmp_r;
    logic [DISP_W-1:0] cmp_d;

    // Single compare process: every strobe and busy/done/collision each cycle.
    always @(negedge clk) begin
        if (fb_clear)
            for (int i = 0; i < DISP_H; i++) model_fb[i] = '0;
        if (reset) begin
            held_coll = 1'b0;
        end else begin
            if (bus.mem_read) begin
                n_reads++;
                if (exp_rd_q.size() == 0) check("mem_read_extra", 64'(bus.mem_read), 64'd0);
                else check("mem_addr", 64'(bus.mem_addr), 64'(exp_rd_q.pop_front()));
            end
            if (bus.fb_rd) begin
                if (exp_row_q.size() == 0) check("fb_rd_extra", 64'(bus.fb_rd), 64'd0);
                else check("fb_rd_row", 64'(bus.fb_row), 64'(exp_row_q[0]));
            end
            if (bus.fb_we) begin
                n_writes++;
                if (aborting || exp_row_q.size() == 0) begin
                    check("fb_we_extra", 64'(bus.fb_we), 64'd0);
                end else begin
                    cmp_r = exp_row_q.pop_front();
                    cmp_d = exp_wd_q.pop_front();
                    check("fb_we_row", 64'(bus.fb_row), 64'(cmp_r));
                    check("fb_wdata", 64'(bus.fb_wdata), 64'(cmp_d));
                    model_fb[cmp_r] = cmp_d;
                end
            end
            if (!aborting) begin
                check("busy", 64'(bus.busy),
                      64'(active && (cyc > start_cyc) && (cyc <= start_cyc + exp_lat)));
                if (bus.done) begin
                    if (!active) begin
                        check("done_extra", 64'(bus.done), 64'd0);
                    end else begin
                        last_lat = cyc - start_cyc;
                        check("latency", 64'(last_lat), 64'(exp_lat));
                        check("collision", 64'(bus.collision), 64'(exp_coll));
                        check("reads_left", 64'(exp_rd_q.size()), 64'd0);
                        check("writes_left", 64'(exp_row_q.size()), 64'd0);
                        held_coll = exp_coll;
                        active    = 1'b0;
                    end
                end else if (active && cyc > start_cyc + exp_lat) begin
                    check("done_missing", 64'(bus.done), 64'd1);
                    active = 1'b0;
                end else if (!active) begin
                    check("collision_hold", 64'(bus.collision), 64'(held_coll));
                end
            end
        end
    end

    // Plans a draw from the rules (pixel lists, edge handling), then pulses start.
    task automatic launch(input int xi, input int yi, input int ni, input int ba,
                          input bit wd, input bit cl);
        int x0, y0, rows, bpr, per, drawn, yy, addr, c;
        logic [7:0] byt;
        logic [DISP_W-1:0] m, old;
        bit coll;
        x0 = xi % DISP_W;
        y0 = yi % DISP_H;
        if (ni != 0) begin rows = ni; bpr = 1; per = MEM_LAT + 4; end
        else if (wd && WIDE_EN != 0) begin rows = 16; bpr = 2; per = 2 * MEM_LAT + 5; end
        else begin rows = 0; bpr = 0; per = 0; end
        drawn = 0;
        coll  = 1'b0;
        for (int r = 0; r < rows; r++) begin
            yy = y0 + r;
            if (cl && yy >= DISP_H) break;
            yy = yy % DISP_H;
            m = '0;
            for (int b = 0; b < bpr; b++) begin
                addr = (ba + r * bpr + b) % (1 << ADDR_W);
                exp_rd_q.push_back(ADDR_W'(addr));
                byt = mem[addr];
                for (int k = 0; k < 8; k++) begin
                    if (byt[7-k]) begin
                        c = x0 + b * 8 + k;
                        if (c >= DISP_W && !cl) c = c - DISP_W;
                        if (c < DISP_W) m[DISP_W-1-c] = 1'b1;
                    end
                end
            end
            old = model_fb[yy];
            if ((old & m) != '0) coll = 1'b1;
            exp_row_q.push_back(yy);
            exp_wd_q.push_back(old ^ m);
            drawn++;
        end
        exp_lat  = drawn * per + 1;
        exp_coll = coll;
        @(negedge clk);
        start_cyc = cyc;
        n_reads   = 0;
        n_writes  = 0;
        active    = 1'b1;
        bus.x         = 8'(xi);
        bus.y         = 8'(yi);
        bus.n         = 4'(ni);
        bus.base_addr = ADDR_W'(ba);
        bus.wide      = wd;
        bus.clip_mode = cl;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && active; i++) @(negedge clk);
        if (active) begin
            check("done_timeout", 64'(bus.done), 64'd1);
            active = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic draw(input int xi, input int yi, input int ni, input int ba,
                        input bit wd, input bit cl);
        launch(xi, yi, ni, ba, wd, cl);
        wait_done();
    endtask

    task automatic clear_fb();
        @(negedge clk);
        fb_clear = 1'b1;
        repeat (2) @(negedge clk);
        fb_clear = 1'b0;
    endtask

    task automatic fb_compare();
        for (int r = 0; r < DISP_H; r++)
            check("fb_contents", 64'(fb_mem[r]), 64'(model_fb[r]));
    endtask

    task automatic outputs_zero();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_collision", 64'(bus.collision), 64'd0);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_fb_rd", 64'(bus.fb_rd), 64'd0);
        check("rst_fb_row", 64'(bus.fb_row), 64'd0);
        check("rst_fb_we", 64'(bus.fb_we), 64'd0);
        check("rst_fb_wdata", 64'(bus.fb_wdata), 64'd0);
    endtask

    initial begin
        int seen;
        for (int a = 0; a < 4096; a++) mem[a] = 8'((a * 37 + 11) & 255);
        mem[0] = 8'hF0;
        mem[1] = 8'hFF;
        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.n = '0;
        bus.base_addr = '0; bus.wide = 1'b0; bus.clip_mode = 1'b0;

        repeat (3) @(negedge clk);
        outputs_zero();
        reset = 1'b0;
        clear_fb();

        // single F0 row at origin, then the same draw erases it
        draw(0, 0, 1, 12'h000, 1'b0, 1'b0);
        check("lit_f0_row0", 64'(fb_mem[0]), 64'hF000_0000_0000_0000);
        check("lit_f0_lat", 64'(last_lat), 64'd7);
        check("lit_f0_coll", 64'(bus.collision), 64'd0);
        draw(0, 0, 1, 12'h000, 1'b0, 1'b0);
        check("lit_erase_row0", 64'(fb_mem[0]), 64'd0);
        check("lit_erase_coll", 64'(bus.collision), 64'd1);

        // horizontal edge: wrap vs clip
        clear_fb();
        draw(60, 0, 1, 12'h001, 1'b0, 1'b0);
        check("lit_xwrap", 64'(fb_mem[0]), 64'hF000_0000_0000_000F);
        clear_fb();
        draw(60, 0, 1, 12'h001, 1'b0, 1'b1);
        check("lit_xclip", 64'(fb_mem[0]), 64'h0000_0000_0000_000F);

        // vertical edge: clip stops after row 31, wrap continues at row 0
        clear_fb();
        draw(0, 30, 4, 12'h020, 1'b0, 1'b1);
        check("lit_yclip_writes", 64'(n_writes), 64'd2);
        check("lit_yclip_lat", 64'(last_lat), 64'd13);
        draw(3, 30, 4, 12'h020, 1'b0, 1'b0);
        check("lit_ywrap_writes", 64'(n_writes), 64'd4);
        check("lit_ywrap_lat", 64'(last_lat), 64'd25);
        fb_compare();

        // SCHIP 16x16 sprite, then the n==0 no-op
        clear_fb();
        draw(4, 2, 0, 12'h300, 1'b1, 1'b0);
        check("lit_wide_reads", 64'(n_reads), 64'd32);
        check("lit_wide_writes", 64'(n_writes), 64'd16);
        check("lit_wide_lat", 64'(last_lat), 64'd145);
        draw(5, 5, 0, 12'h300, 1'b0, 1'b0);
        check("lit_noop_lat", 64'(last_lat), 64'd1);
        check("lit_noop_reads", 64'(n_reads), 64'd0);
        check("lit_noop_writes", 64'(n_writes), 64'd0);

        // wide sprite clipped on both edges; x/y reduction and address wrap
        draw(56, 20, 0, 12'h340, 1'b1, 1'b1);
        check("lit_wclip_reads", 64'(n_reads), 64'd24);
        check("lit_wclip_lat", 64'(last_lat), 64'd109);
        draw(70, 40, 3, 12'hFFE, 1'b0, 1'b0);
        check("lit_modwrap_lat", 64'(last_lat), 64'd19);
        fb_compare();

        // start while busy must be ignored
        launch(10, 12, 2, 12'h050, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.x = 8'd9; bus.n = 4'd5; bus.base_addr = 12'h123; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        fb_compare();

        // reset during the FBWAIT of row 1: row 0 stays written, row 1 never
        clear_fb();
        launch(0, 5, 3, 12'h010, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.fb_rd) seen++;
        end
        check("abort_fb_rd_seen", 64'(seen), 64'd2);
        aborting = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        outputs_zero();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_idle_busy", 64'(bus.busy), 64'd0);
        active = 1'b0;
        exp_rd_q.delete();
        exp_row_q.delete();
        exp_wd_q.delete();
        aborting = 1'b0;
        check("abort_row6_untouched", 64'(fb_mem[6]), 64'd0);
        fb_compare();
        draw(1, 1, 2, 12'h040, 1'b0, 1'b0);
        check("post_reset_lat", 64'(last_lat), 64'd13);
        fb_compare();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
